// File: rtl/spi_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_responder
//
// SPI target, mode 0 (CPOL=0, CPHA=0), MSB first. An external host uses it to
// exchange bytes with the peripherals bus. SCLK, CS_N and MOSI are asynchronous
// to raw_clk. Each one goes through a SYNC_STAGES-deep synchroniser and is then
// edge-detected inside the raw_clk domain.
//
// Parameters
//   SYNC_STAGES  flops in each input synchroniser (must be >= 2)
//   FILL_BYTE    byte shifted out when no TX byte is queued
//
// Ports
//   raw_clk         in   system clock; all state changes on its rising edge
//   reset           in   asynchronous, active-low reset
//   spi_sclk        in   SPI clock from the host (async)
//   spi_cs_n        in   chip select, active low (async)
//   spi_mosi        in   host-to-target data (async)
//   spi_miso        out  target-to-host data (1 while not selected)
//   spi_miso_oe     out  MISO output enable, 1 only while selected
//   tx_data         in   byte to send next
//   tx_strobe       in   one-cycle pulse: latch tx_data into the TX buffer
//   tx_full         out  TX buffer holds a byte not yet loaded into the shifter
//   rx_data         out  last complete received byte
//   rx_ready        out  rx_data is valid and unread
//   rx_ready_clear  in   one-cycle pulse: consume rx_data
//   overrun         out  sticky: a byte arrived while rx_ready was 1
//   overrun_clear   in   one-cycle pulse: clear overrun
//   busy            out  1 while a transaction is in progress (state ACTIVE)
//   dbg_state       out  current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Byte handshakes:
//   TX: tx_strobe writes tx_buf and sets tx_full, even when tx_full is already
//   set (the newer byte replaces the older one). tx_full clears when the
//   shifter takes the byte. RX: rx_ready is the valid flag for rx_data, and
//   rx_ready_clear is the consumer acknowledging it. A new byte that completes
//   while rx_ready=1 and is not being cleared in that cycle sets overrun. On any
//   same-cycle collision, the event that sets a flag takes priority over the
//   pulse that clears it.
// -----------------------------------------------------------------------------
module spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hff
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       overrun,
  input  logic       overrun_clear,
  output logic       busy,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;

  // Synchroniser chains. The newest sample enters at bit 0. The synced value
  // is the top bit.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  logic [2:0] bit_cnt;
  logic [7:0] shifter;     // outgoing byte; MISO is always its MSB
  logic [7:0] shift_in;    // incoming byte, assembled MSB first
  logic [7:0] tx_buf;
  logic [7:0] load_byte;
  logic       rx_pending;  // the 8th rise happened on the previous cycle

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  // CS resets to the "selected" level. If CS is already low when reset is
  // released, no falling edge is seen. The host must therefore deselect and
  // then reselect before a transaction can start, so the responder never joins
  // a transfer halfway through a byte.
  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Byte the shifter takes at CS assert and at every byte boundary.
  assign load_byte = tx_full ? tx_buf : FILL_BYTE;

  // The shifter is parked at all-ones while idle, so MISO idles high without
  // needing a separate output register.
  assign spi_miso  = shifter[7];
  assign dbg_state = (state == ACTIVE);

  // ---------------------------------------------------------------------------
  // Transaction FSM with the RX/TX byte flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shifter     <= 8'hff;
      shift_in    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      rx_pending  <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            shifter     <= load_byte;
            tx_full     <= 1'b0;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // A partial RX byte is dropped here, because rx_pending is never
            // raised for it. Whatever is in the shifter is lost. tx_buf is
            // kept.
            state       <= IDLE;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            shifter     <= 8'hff;
          end else if (sclk_rise) begin
            shift_in <= {shift_in[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_pending <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              shifter <= {shifter[6:0], 1'b1};
            end else begin
              // Byte boundary. The next byte goes out with no CS toggle.
              shifter <= load_byte;
              tx_full <= 1'b0;
            end
          end
        end
      endcase

      // Commit the received byte one cycle after the 8th rise, once shift_in
      // holds all eight bits.
      if (rx_pending) begin
        rx_data  <= shift_in;
        rx_ready <= 1'b1;
      end else if (rx_ready_clear) begin
        rx_ready <= 1'b0;
      end

      if (overrun_clear) begin
        overrun <= 1'b0;
      end
      if (rx_pending && rx_ready && !rx_ready_clear) begin
        overrun <= 1'b1;
      end

      // Placed after the FSM so that a strobe in the same cycle as a shifter
      // load leaves the new byte queued. The shifter has already taken the old
      // tx_buf value.
      if (tx_strobe) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;   // raw_clk cycles per SCLK phase

  logic       raw_clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear = 1'b0;
  logic       overrun;
  logic       overrun_clear = 1'b0;
  logic       busy;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 raw_clk = ~raw_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  spi_responder #(
    .SYNC_STAGES(SYNC),
    .FILL_BYTE  (8'hff)
  ) dut (
    .raw_clk       (raw_clk),
    .reset         (reset),
    .spi_sclk      (spi_sclk),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .tx_data       (tx_data),
    .tx_strobe     (tx_strobe),
    .tx_full       (tx_full),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_ready_clear(rx_ready_clear),
    .overrun       (overrun),
    .overrun_clear (overrun_clear),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge raw_clk);
    #1;
  endtask

  // Host side of mode 0. MOSI is set while SCLK is low, and MISO is sampled
  // just before the rising edge.
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = d[i];
      tick(HALF);
      got[i] = spi_miso;
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_release();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic send_tx(input logic [7:0] d);
    tx_data = d;
    tx_strobe = 1'b1;
    tick(1);
    tx_strobe = 1'b0;
    tick(1);
  endtask

  task automatic pulse_rx_clear();
    rx_ready_clear = 1'b1;
    tick(1);
    rx_ready_clear = 1'b0;
    tick(1);
  endtask

  task automatic pulse_ovr_clear();
    overrun_clear = 1'b1;
    tick(1);
    overrun_clear = 1'b0;
    tick(1);
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rx_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick(3);
    reset = 1'b1;
    tick(3);
    checks++;
    if ({spi_miso, spi_miso_oe, tx_full, rx_ready, overrun, busy, dbg_state} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 1000000",
               {spi_miso, spi_miso_oe, tx_full, rx_ready, overrun, busy, dbg_state});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
  endtask

  task automatic test_basic();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    send_tx(8'hA5);
    checks++;
    if (tx_full !== 1'b1) begin
      errors++;
      $display("FAIL basic_tx_full_set: got %b expected 1", tx_full);
    end
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    cs_assert();
    checks++;
    if ({busy, spi_miso_oe, dbg_state} !== 3'b111) begin
      errors++;
      $display("FAIL basic_active: got %b expected 111", {busy, spi_miso_oe, dbg_state});
    end
    spi_bits(8'h3C, 8, got);
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL basic_miso: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp) begin
      errors++;
      $display("FAIL basic_rx: got %h ready %b expected %h ready 1", rx_data, rx_ready, exp);
    end
    checks++;
    if (tx_full !== 1'b0) begin
      errors++;
      $display("FAIL basic_tx_full_clr: got %b expected 0", tx_full);
    end
    cs_release();
    checks++;
    if ({busy, spi_miso_oe, spi_miso} !== 3'b001) begin
      errors++;
      $display("FAIL basic_idle: got %b expected 001", {busy, spi_miso_oe, spi_miso});
    end
    pulse_rx_clear();
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_rx_clear: got %b expected 0", rx_ready);
    end
  endtask

  task automatic test_fill();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h00);
    cs_assert();
    spi_bits(8'h00, 8, got);
    cs_release();
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL fill_miso: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp) begin
      errors++;
      $display("FAIL fill_rx: got %h ready %b expected %h ready 1", rx_data, rx_ready, exp);
    end
    pulse_rx_clear();
  endtask

  task automatic test_idle_sclk();
    logic [7:0] got;
    spi_cs_n = 1'b1;
    spi_bits(8'h5A, 8, got);
    tick(10);
    checks++;
    if (got !== 8'hFF || {rx_ready, busy, spi_miso_oe} !== 3'b000) begin
      errors++;
      $display("FAIL idle_sclk: got miso %h flags %b expected ff 000",
               got, {rx_ready, busy, spi_miso_oe});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h11);
    exp_rx_q.push_back(8'h22);
    cs_assert();
    spi_bits(8'h11, 8, got);
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_miso0: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rx0: got %h ovr %b expected %h ovr 0", rx_data, overrun, exp);
    end
    spi_bits(8'h22, 8, got);
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_miso1: got %h expected %h", got, exp);
    end
    tick(4);
    exp = exp_rx_q.pop_front();
    checks++;
    if (rx_data !== exp || overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rx1: got %h ovr %b expected %h ovr 1", rx_data, overrun, exp);
    end
    cs_release();
    pulse_ovr_clear();
    checks++;
    if ({overrun, rx_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_ovr_clear: got %b expected 01", {overrun, rx_ready});
    end
    pulse_rx_clear();
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    cs_assert();
    spi_bits(8'hF0, 5, got);
    cs_release();
    tick(10);
    checks++;
    if ({rx_ready, overrun, busy, spi_miso_oe, spi_miso} !== 5'b00001) begin
      errors++;
      $display("FAIL abort_state: got %b expected 00001",
               {rx_ready, overrun, busy, spi_miso_oe, spi_miso});
    end
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h81);
    cs_assert();
    spi_bits(8'h81, 8, got);
    cs_release();
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL abort_miso: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL abort_rx: got %h ovr %b expected %h ovr 0", rx_data, overrun, exp);
    end
    pulse_rx_clear();
  endtask

  task automatic test_strobe_collision();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    send_tx(8'h66);
    exp_miso_q.push_back(8'h66);
    exp_miso_q.push_back(8'h55);
    exp_rx_q.push_back(8'h12);
    exp_rx_q.push_back(8'h34);
    // The CS fall is acted on SYNC+1 edges after it is driven. The strobe is
    // placed on that same edge.
    spi_cs_n = 1'b0;
    tick(SYNC);
    tx_data = 8'h55;
    tx_strobe = 1'b1;
    tick(1);
    tx_strobe = 1'b0;
    checks++;
    if ({busy, tx_full} !== 2'b11) begin
      errors++;
      $display("FAIL coll_tx_full: got %b expected 11", {busy, tx_full});
    end
    tick(HALF);
    spi_bits(8'h12, 8, got);
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL coll_miso0: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp) begin
      errors++;
      $display("FAIL coll_rx0: got %h expected %h", rx_data, exp);
    end
    pulse_rx_clear();
    spi_bits(8'h34, 8, got);
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL coll_miso1: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coll_rx1: got %h ovr %b expected %h ovr 0", rx_data, overrun, exp);
    end
    cs_release();
    checks++;
    if (tx_full !== 1'b0) begin
      errors++;
      $display("FAIL coll_tx_drained: got %b expected 0", tx_full);
    end
    pulse_rx_clear();
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic [7:0] exp;
    bit ok;
    cs_assert();
    spi_bits(8'hAA, 8, got);
    wait_rx(ok);
    send_tx(8'h77);
    spi_bits(8'h0F, 4, got);
    reset = 1'b0;
    #1;
    checks++;
    if ({spi_miso, spi_miso_oe, tx_full, rx_ready, overrun, busy, dbg_state} !== 7'b1000000) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 1000000",
               {spi_miso, spi_miso_oe, tx_full, rx_ready, overrun, busy, dbg_state});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_rx_data: got %h expected 00", rx_data);
    end
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'hC3);
    cs_assert();
    spi_bits(8'hC3, 8, got);
    cs_release();
    exp = exp_miso_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_miso: got %h expected %h", got, exp);
    end
    wait_rx(ok);
    exp = exp_rx_q.pop_front();
    checks++;
    if (!ok || rx_data !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rx: got %h ovr %b expected %h ovr 0", rx_data, overrun, exp);
    end
    pulse_rx_clear();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_idle_sclk();
    test_back_to_back();
    test_abort();
    test_strobe_collision();
    test_reset_mid();
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
